// File: rtl/comm_pkg.sv
// comm_pkg
// Definitions shared by the comm controller and the sparse row unpacker:
//   - data_width(): packed row word width for a given MATRIX_N/HEADER
//   - hdr_msb()/val_msb()/idx_msb(): top bit of each field in the word
//   - HDR_MSB/VAL_MSB/IDX_MSB: the same offsets for the default 4x4, 1-byte header build
//   - ENTRY_W: width of one value or index entry
//   - state_t: unpacker state encoding
// No ports; this is a package.
package comm_pkg;

    localparam int ENTRY_W      = 16;
    localparam int DEF_MATRIX_N = 4;
    localparam int DEF_HEADER   = 1;

    // Word layout, MSB first: header bytes, values field, indices field.
    function automatic int data_width(input int matrix_n, input int header);
        return 8 * header + 2 * ENTRY_W * matrix_n;
    endfunction

    function automatic int hdr_msb(input int matrix_n, input int header);
        return data_width(matrix_n, header) - 1;
    endfunction

    function automatic int val_msb(input int matrix_n);
        return 2 * ENTRY_W * matrix_n - 1;
    endfunction

    function automatic int idx_msb(input int matrix_n);
        return ENTRY_W * matrix_n - 1;
    endfunction

    localparam int HDR_MSB = hdr_msb(DEF_MATRIX_N, DEF_HEADER);
    localparam int VAL_MSB = val_msb(DEF_MATRIX_N);
    localparam int IDX_MSB = idx_msb(DEF_MATRIX_N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sparse_row_unpacker.sv
// sparse_row_unpacker
// Captures one packed sparse row/col word on rx_complete, validates its byte-count
// header, then streams the non-zero entries as (value, index) pairs, one per cycle,
// over a valid/ready handshake.
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   rx_complete, rx_data one-cycle capture strobe and packed row word
//   out_ready            consumer can accept an entry
//   out_valid/out_value/out_index/out_last   registered entry stream
//   row_done             pulse after the last entry handshakes
//   err_size             pulse when a row is dropped for a bad header
//   err_overrun          sticky: a word arrived while a row was in flight
//   busy                 state is not IDLE
module sparse_row_unpacker
    import comm_pkg::*;
#(
    parameter int  MATRIX_N   = 4,
    parameter int  HEADER     = 1,
    localparam int DATA_WIDTH = data_width(MATRIX_N, HEADER)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_complete,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ENTRY_W-1:0]    out_value,
    output logic [ENTRY_W-1:0]    out_index,
    output logic                  out_last,
    output logic                  row_done,
    output logic                  err_size,
    output logic                  err_overrun,
    output logic                  busy
);

    localparam int HDR_W   = 8 * HEADER;
    localparam int NB_W    = HDR_W + 1;
    localparam int FIELD_W = ENTRY_W * MATRIX_N;
    localparam int CNT_W   = $clog2(MATRIX_N + 1);
    localparam int H_MSB   = hdr_msb(MATRIX_N, HEADER);
    localparam int V_MSB   = val_msb(MATRIX_N);
    localparam int I_MSB   = idx_msb(MATRIX_N);

    state_t                state;
    logic [DATA_WIDTH-1:0] row_word;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      k;

    logic [HDR_W-1:0]      nbytes;
    logic [FIELD_W-1:0]    val_field;
    logic [FIELD_W-1:0]    idx_field;
    logic                  header_ok;
    logic [CNT_W-1:0]      hdr_cnt;
    logic [CNT_W-1:0]      k_next;

    assign nbytes    = row_word[H_MSB -: HDR_W];
    assign val_field = row_word[V_MSB -: FIELD_W];
    assign idx_field = row_word[I_MSB -: FIELD_W];

    // Compare one bit wider than the header so 2*MATRIX_N can never wrap.
    assign header_ok = (nbytes != '0) && !nbytes[0] &&
                       ({1'b0, nbytes} <= NB_W'(2 * MATRIX_N));
    assign hdr_cnt   = CNT_W'(nbytes >> 1);
    assign k_next    = k + CNT_W'(1);
    assign busy      = (state != ST_IDLE);

    // Entries are right-aligned with entry 0 most significant, so entry k of n
    // sits (n-1-k) slots up from bit 0. Shifting by {sel,4'b0} is sel*16, which
    // relies on ENTRY_W being 16.
    function automatic logic [ENTRY_W-1:0] pick(input logic [FIELD_W-1:0] field,
                                                input logic [CNT_W-1:0]   n,
                                                input logic [CNT_W-1:0]   idx);
        logic [CNT_W-1:0]   sel;
        logic [FIELD_W-1:0] shifted;
        sel     = n - idx - CNT_W'(1);
        shifted = field >> {sel, 4'b0000};
        return shifted[ENTRY_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            row_word    <= '0;
            cnt         <= '0;
            k           <= '0;
            out_valid   <= 1'b0;
            out_value   <= '0;
            out_index   <= '0;
            out_last    <= 1'b0;
            row_done    <= 1'b0;
            err_size    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            row_done <= 1'b0;
            err_size <= 1'b0;

            // A word is only ever captured in IDLE; anything else is an overrun.
            if (rx_complete && (state != ST_IDLE)) begin
                err_overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_complete) begin
                        row_word <= rx_data;
                        state    <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (!header_ok) begin
                        err_size <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt       <= hdr_cnt;
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_value <= pick(val_field, hdr_cnt, '0);
                        out_index <= pick(idx_field, hdr_cnt, '0);
                        out_last  <= (hdr_cnt == CNT_W'(1));
                        state     <= ST_EMIT;
                    end
                end

                // out_valid is always high here, so out_ready alone marks a handshake.
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            row_done  <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            k         <= k_next;
                            out_value <= pick(val_field, cnt, k_next);
                            out_index <= pick(idx_field, cnt, k_next);
                            out_last  <= (k_next == cnt - CNT_W'(1));
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_row_unpacker.sv
// tb_sparse_row_unpacker
// Self-checking bench for sparse_row_unpacker (MATRIX_N=4, HEADER=1, 136-bit words).
module tb_sparse_row_unpacker;

    localparam int DW = 136;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rx_complete;
    logic [DW-1:0] rx_data;
    logic          out_ready;
    logic          out_valid;
    logic [15:0]   out_value;
    logic [15:0]   out_index;
    logic          out_last;
    logic          row_done;
    logic          err_size;
    logic          err_overrun;
    logic          busy;

    always #5 clk = ~clk;

    sparse_row_unpacker #(.MATRIX_N(4), .HEADER(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_complete (rx_complete),
        .rx_data     (rx_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_value   (out_value),
        .out_index   (out_index),
        .out_last    (out_last),
        .row_done    (row_done),
        .err_size    (err_size),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    // Observations collected by applyStimulus for one row.
    int          cyc;
    int          firstValidCyc;
    int          doneCyc;
    int          errCyc;
    int          idleCyc;
    int          doneCount;
    int          errCount;
    int          holdBad;
    int          bothHigh;
    logic [15:0] gotVals[$];
    logic [15:0] gotIdx[$];
    bit          gotLast[$];

    typedef struct {
        logic [7:0]  nb;
        logic [63:0] vals;
        logic [63:0] idxs;
        int          expBeats;
        bit          expErr;
        logic [15:0] expFirstVal;
        logic [15:0] expFirstIdx;
        logic [15:0] expLastVal;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model straight from the word format: count = nbytes/2 when the
    // header is legal, entry k taken from the top of the right-aligned field.
    function automatic int modelCount(input logic [DW-1:0] w);
        int nb;
        nb = int'(w[DW-1 -: 8]);
        if (nb == 0 || (nb % 2) != 0 || nb > 8) return 0;
        return nb / 2;
    endfunction

    function automatic logic [15:0] modelValue(input logic [DW-1:0] w, input int k);
        logic [63:0] vf;
        int          n;
        vf = w[127:64];
        n  = modelCount(w);
        return vf[16*(n-k)-1 -: 16];
    endfunction

    function automatic logic [15:0] modelIndex(input logic [DW-1:0] w, input int k);
        logic [63:0] xf;
        int          n;
        xf = w[63:0];
        n  = modelCount(w);
        return xf[16*(n-k)-1 -: 16];
    endfunction

    // Send one word and run the consumer side until the block returns to IDLE.
    task automatic applyStimulus(input logic [DW-1:0] w, input bit randReady,
                                 input int stallBeat, input int overrunBeat,
                                 input logic [DW-1:0] w2);
        int          stallLeft;
        bit          injected;
        bit          prevStall;
        logic [15:0] hv;
        logic [15:0] hi;
        logic        hl;
        gotVals.delete();
        gotIdx.delete();
        gotLast.delete();
        firstValidCyc = -1;
        doneCyc       = -1;
        errCyc        = -1;
        idleCyc       = -1;
        doneCount     = 0;
        errCount      = 0;
        holdBad       = 0;
        bothHigh      = 0;
        stallLeft     = 3;
        injected      = 0;
        prevStall     = 0;
        hv            = '0;
        hi            = '0;
        hl            = 1'b0;
        rx_data       = w;
        rx_complete   = 1'b1;
        out_ready     = 1'b1;
        tick();
        cyc = 1;
        for (int c = 0; c < 80; c++) begin
            rx_complete = 1'b0;
            if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (row_done) begin doneCount++; doneCyc = cyc; end
            if (err_size) begin errCount++; errCyc = cyc; end
            if (row_done && err_size) bothHigh = 1;
            if (prevStall && (!out_valid || out_value !== hv || out_index !== hi ||
                              out_last !== hl)) holdBad++;
            if (!busy) begin
                idleCyc = cyc;
                break;
            end
            if (overrunBeat >= 0 && !injected && out_valid &&
                gotVals.size() == overrunBeat) begin
                rx_data     = w2;
                rx_complete = 1'b1;
                injected    = 1;
            end
            if (stallBeat >= 0 && out_valid && gotVals.size() == stallBeat &&
                stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else if (randReady) begin
                out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                out_ready = 1'b1;
            end
            prevStall = out_valid && !out_ready;
            hv = out_value;
            hi = out_index;
            hl = out_last;
            if (out_valid && out_ready) begin
                gotVals.push_back(out_value);
                gotIdx.push_back(out_index);
                gotLast.push_back(out_last);
            end
            tick();
            cyc++;
        end
        rx_complete = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic compareRow(input logic [DW-1:0] w, input string tag);
        int n;
        n = modelCount(w);
        checkOutput({tag, " idle reached"}, (idleCyc >= 0), 1);
        checkOutput({tag, " beats"}, gotVals.size(), n);
        checkOutput({tag, " err_size"}, errCount, (n == 0) ? 1 : 0);
        checkOutput({tag, " row_done"}, doneCount, (n == 0) ? 0 : 1);
        checkOutput({tag, " done+err same cycle"}, bothHigh, 0);
        checkOutput({tag, " hold stable"}, holdBad, 0);
        for (int k = 0; k < n && k < gotVals.size(); k++) begin
            checkOutput($sformatf("%s value[%0d]", tag, k), gotVals[k], modelValue(w, k));
            checkOutput($sformatf("%s index[%0d]", tag, k), gotIdx[k], modelIndex(w, k));
            checkOutput($sformatf("%s last[%0d]", tag, k), gotLast[k], (k == n - 1));
        end
        if (n == 0) begin
            checkOutput({tag, " no valid"}, firstValidCyc, -1);
            checkOutput({tag, " err cycle"}, errCyc, 2);
            checkOutput({tag, " idle cycle"}, idleCyc, 2);
        end else begin
            checkOutput({tag, " first valid cycle"}, firstValidCyc, 2);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] w2;
        logic [7:0]    nb;
        int            stray;

        vecs[0] = '{8'd8,  64'h0011_0022_0033_0044, 64'h0000_0001_0002_0003, 4, 0, 16'h0011, 16'h0000, 16'h0044};
        vecs[1] = '{8'd2,  64'hAAAA_BBBB_CCCC_BEEF, 64'h0009_0008_0007_0003, 1, 0, 16'hBEEF, 16'h0003, 16'hBEEF};
        vecs[2] = '{8'd0,  64'h1111_2222_3333_4444, 64'h0000_0001_0002_0003, 0, 1, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{8'd5,  64'h1111_2222_3333_4444, 64'h0000_0001_0002_0003, 0, 1, 16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{8'd10, 64'h1111_2222_3333_4444, 64'h0000_0001_0002_0003, 0, 1, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{8'd6,  64'hFFFF_1234_5678_9ABC, 64'h0001_0007_0005_0002, 3, 0, 16'h1234, 16'h0007, 16'h9ABC};

        resetn      = 1'b0;
        rx_complete = 1'b0;
        rx_data     = '0;
        out_ready   = 1'b0;
        repeat (3) tick();
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err_overrun", err_overrun, 0);
        checkOutput("reset row_done", row_done, 0);
        checkOutput("reset err_size", err_size, 0);
        checkOutput("reset out_last", out_last, 0);
        resetn = 1'b1;
        tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            w = {vecs[i].nb, vecs[i].vals, vecs[i].idxs};
            applyStimulus(w, 1'b0, -1, -1, '0);
            checkOutput($sformatf("vec%0d beats", i), gotVals.size(), vecs[i].expBeats);
            checkOutput($sformatf("vec%0d err", i), errCount, vecs[i].expErr);
            if (vecs[i].expBeats > 0) begin
                checkOutput($sformatf("vec%0d first value", i), gotVals[0], vecs[i].expFirstVal);
                checkOutput($sformatf("vec%0d first index", i), gotIdx[0], vecs[i].expFirstIdx);
                checkOutput($sformatf("vec%0d last value", i), gotVals[gotVals.size()-1],
                            vecs[i].expLastVal);
                checkOutput($sformatf("vec%0d done cycle", i), doneCyc, 2 + vecs[i].expBeats);
                checkOutput($sformatf("vec%0d idle cycle", i), idleCyc, 3 + vecs[i].expBeats);
            end
            compareRow(w, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d no overrun", i), err_overrun, 0);
        end

        $display("[TB] backpressure on second beat");
        w = {8'd8, 64'h0011_0022_0033_0044, 64'h0000_0001_0002_0003};
        applyStimulus(w, 1'b0, 1, -1, '0);
        compareRow(w, "stall");
        checkOutput("stall second value", gotVals[1], 16'h0022);
        checkOutput("stall done cycle", doneCyc, 9);

        $display("[TB] overrun during third beat");
        w2 = {8'd4, 64'h0000_0000_0AAA_0BBB, 64'h0000_0000_0003_0002};
        applyStimulus(w, 1'b0, -1, 2, w2);
        compareRow(w, "overrun row");
        checkOutput("overrun flag", err_overrun, 1);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || busy) stray++;
            tick();
        end
        checkOutput("overrun word not emitted", stray, 0);
        w = {8'd2, 64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_0003};
        applyStimulus(w, 1'b0, -1, -1, '0);
        compareRow(w, "after overrun");
        checkOutput("overrun sticky", err_overrun, 1);

        $display("[TB] random rows");
        for (int i = 0; i < 25; i++) begin
            nb = 8'($urandom_range(0, 10));
            w  = {nb, $urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(w, 1'b1, -1, -1, '0);
            compareRow(w, $sformatf("rand%0d", i));
        end

        $display("[TB] reset mid-row");
        w = {8'd8, 64'h0011_0022_0033_0044, 64'h0000_0001_0002_0003};
        rx_data     = w;
        rx_complete = 1'b1;
        out_ready   = 1'b1;
        tick();
        rx_complete = 1'b0;
        tick();
        tick();
        checkOutput("midrow second beat", out_value, 16'h0022);
        resetn = 1'b0;
        tick();
        checkOutput("midrow out_valid", out_valid, 0);
        checkOutput("midrow busy", busy, 0);
        checkOutput("midrow err_overrun", err_overrun, 0);
        checkOutput("midrow row_done", row_done, 0);
        resetn = 1'b1;
        tick();
        applyStimulus(w, 1'b0, -1, -1, '0);
        compareRow(w, "post reset");
        checkOutput("post reset done cycle", doneCyc, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sparse_row_unpacker.md
Name: sparse_row_unpacker

Overview:
- Sits directly downstream of the comm controller's receive path.
- Captures one packed sparse row/col word on the controller's one-cycle rx_complete strobe.
- Validates the header, then streams the non-zero entries one per cycle as (value, index) pairs over a valid/ready handshake to the multiply datapath.
- Drops malformed rows with an error pulse. Flags words that arrive while a row is still streaming.

Parameters:
- MATRIX_N, 4: matrix dimension; maximum number of entries per row/col.
- HEADER, 1: header size in bytes.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- rx_complete  in  1  one-cycle strobe from the comm controller; rx_data is valid only in this cycle.
- rx_data  in  DATA_WIDTH  packed row word; DATA_WIDTH = 8*HEADER + 32*MATRIX_N.
- out_ready  in  1  consumer can accept an entry.
- out_valid  out  1  out_value/out_index/out_last are valid.
- out_value  out  16  entry value.
- out_index  out  16  entry column/row index.
- out_last  out  1  final entry of the row.
- row_done  out  1  one-cycle pulse after the last entry handshakes.
- err_size  out  1  one-cycle pulse: header invalid, row dropped.
- err_overrun  out  1  sticky; cleared only by reset.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clocking: one clock. resetn is synchronous, active-low, sampled at posedge clk.
- Word format (MSB first):
  - nbytes = rx_data[DATA_WIDTH-1 -: 8*HEADER]
  - values field = next 16*MATRIX_N bits
  - indices field = low 16*MATRIX_N bits
- nbytes is the byte length of the values field, so entry count = nbytes/2.
- Entries are right-aligned in each field; the first-received entry is most significant.
- Entry k (0-based, k < cnt): value = values_field[16*(cnt-k)-1 -: 16]; index = indices_field[16*(cnt-k)-1 -: 16].
- Header is valid iff nbytes != 0, nbytes is even, and nbytes <= 2*MATRIX_N.
- Reset values: all outputs 0, err_overrun cleared, state IDLE, entry counter 0, capture register 0.
- States:
  - IDLE: on rx_complete, capture rx_data into the internal register at that edge → CHECK. Otherwise stay.
  - CHECK: header invalid → pulse err_size, → IDLE. Valid → load cnt, set k=0, → EMIT.
  - EMIT: out_valid=1 with entry k. out_last = (k == cnt-1).
    - On out_valid && out_ready: k++. If the last entry was accepted → DONE.
  - DONE: pulse row_done, → IDLE.
- Latency: rx_complete in cycle T → out_valid first high in cycle T+2.
- Throughput: one entry per cycle while out_ready=1.
- Handshake: while out_valid && !out_ready, out_value/out_index/out_last hold stable. out_valid never drops without a handshake, except on reset.
- Outputs are registered: out_valid/out_value/out_index/out_last update on the edge that enters EMIT or completes a handshake.
- rx_complete while not in IDLE (CHECK/EMIT/DONE): word ignored, err_overrun set, current row unaffected.
- rx_complete in the same cycle DONE returns to IDLE: ignored and overrun flagged. Capture happens only when the state is IDLE.
- row_done and err_size are never high in the same cycle.
- Reset asserted mid-row: at the next edge, out_valid=0, state=IDLE, partial row discarded, no row_done.
- Arithmetic: k and cnt are $clog2(MATRIX_N+1) bits wide. nbytes is compared at 8*HEADER+1 bits to avoid overflow.

Decomposition:
- Shared package comm_pkg holds:
  - DATA_WIDTH computation as a function of MATRIX_N/HEADER;
  - field offset constants (HDR_MSB, VAL_MSB, IDX_MSB);
  - ENTRY_W = 16;
  - the state enum typedef.
- This package is also used by the comm controller.
- No sub-module; entry selection is an indexed part-select inside this block.

Test Plan:
(All with MATRIX_N=4, HEADER=1, DATA_WIDTH=136.)
- Full row: nbytes=8; values 0x0011,0x0022,0x0033,0x0044; indices 0,1,2,3; out_ready=1.
  → beats at T+2..T+5 in that order; out_last on the 4th beat; row_done at T+6; busy low at T+7.
- Single entry: nbytes=2; values_field[15:0]=0xBEEF; indices_field[15:0]=3.
  → one beat (0xBEEF, 3) with out_last=1, then row_done.
- Backpressure: full row with out_ready=0 for 3 cycles during the 2nd beat.
  → 0x0022/1 held stable all 3 cycles; no beat lost or duplicated; 4 handshakes total.
- Bad headers: nbytes = 0, then 5, then 10 in separate words.
  → err_size pulses at T+2 each time; out_valid stays 0; busy low again at T+2.
- Overrun: second rx_complete during the 3rd beat.
  → err_overrun=1 and sticky; first row completes unchanged; second word not emitted.
- Reset mid-row: resetn=0 during the 2nd beat.
  → next edge: out_valid=0, busy=0, err_overrun=0; a subsequent valid row streams normally.
